fetch_stage_ctrl: RTL and testbench

//   Fetch-side consumer of the hazard unit's stall and IF_Flush outputs. Owns the PC register
//   and the IF/ID pipeline latch of the 16-bit 5-stage core.
//   - stall: freezes PC and IF/ID.
//   - if_flush: squashes the wrong-path fetch and redirects PC to the resolved branch target.
//   - HLT fetch: stops PC advance.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/pc_register.sv | 31 +++
 rtl/fetch_stage_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_stage_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, fetch constants and the IF/ID record for the 16-bit 5-stage core fetch stage.
package fetch_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;
    localparam logic [3:0]        HLT_OPC  = 4'hF;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc_plus2;
        logic              valid;
    } if_id_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter: async-reset register with write-enable and a next-value mux
// selecting sequential (+2) or redirect target; holding is expressed by we=0.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            selTarget,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pcPlus2
);

    logic [PC_W-1:0] pcNext;

    // Modulo-2^16 increment; 16'hFFFE rolls over to 16'h0000 silently.
    assign pcPlus2 = pc + PC_W'(2);
    assign pcNext  = selTarget ? target : pcPlus2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (we) begin
            pc <= pcNext;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC, IF/ID latch and HLT state under stall / IF_Flush control.
// Optional stall/flush performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0000,
    parameter logic [3:0]        HLT_OPC  = 4'hF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              if_flush,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] if_id_inst,
    output logic [PC_W-1:0]   if_id_pc_plus2,
    output logic              if_id_valid,
    output logic              fetch_halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    fetch_state_e    state, stateNext;
    if_id_t          ifId_p1, ifIdNext;
    logic            pcWe, pcSelTarget, hltFetch;
    logic [PC_W-1:0] pc, pcPlus2;

    assign hltFetch = (imem_data[15:12] == HLT_OPC);

    pc_register #(
        .RESET_PC (RESET_PC)
    ) uPcReg (
        .clk       (clk),
        .rst       (rst),
        .we        (pcWe),
        .selTarget (pcSelTarget),
        .target    (br_target),
        .pc        (pc),
        .pcPlus2   (pcPlus2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Stall outranks flush: branch operands are unresolved while stalled.
    always_comb begin
        stateNext   = state;
        pcWe        = 1'b0;
        pcSelTarget = 1'b0;
        ifIdNext    = ifId_p1;
        if (!stall) begin
            if (if_flush) begin
                pcWe        = 1'b1;
                pcSelTarget = 1'b1;
                ifIdNext    = '{inst: NOP_INST, pc_plus2: '0, valid: 1'b0};
                stateNext   = RUN;
            end else if (state == HALT || hltFetch) begin
                ifIdNext  = '{inst: imem_data, pc_plus2: pcPlus2, valid: 1'b1};
                stateNext = HALT;
            end else begin
                pcWe     = 1'b1;
                ifIdNext = '{inst: imem_data, pc_plus2: pcPlus2, valid: 1'b1};
            end
        end
    end

    // IF -> ID boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifId_p1 <= '{inst: NOP_INST, pc_plus2: '0, valid: 1'b0};
        end else begin
            ifId_p1 <= ifIdNext;
        end
    end

    assign imem_addr      = pc;
    assign if_id_inst     = ifId_p1.inst;
    assign if_id_pc_plus2 = ifId_p1.pc_plus2;
    assign if_id_valid    = ifId_p1.valid;
    assign fetch_halted   = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= satInc(stall_cnt);
            end
            if (if_flush && !stall) begin
                flush_cnt <= satInc(flush_cnt);
            end
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: vector table plus hand sequences for async reset.
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_flush;
    logic [15:0] br_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        fetch_halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int nCmp  = 0;
    int nFail = 0;

    fetch_stage_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_flush       (if_flush),
        .br_target      (br_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .fetch_halted   (fetch_halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: HLT at 0x0020, 16'h1234 everywhere else.
    always_comb begin
        imem_data = (imem_addr == 16'h0020) ? 16'hF000 : 16'h1234;
    end

    typedef struct {
        logic        stl;
        logic        fl;
        logic [15:0] tgt;
        logic [15:0] expAddr;
        logic [15:0] expInst;
        logic [15:0] expPc2;
        logic        expValid;
        logic        expHalt;
        logic [15:0] expStallCnt;
        logic [15:0] expFlushCnt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic stl, input logic fl, input logic [15:0] tgt,
                                input logic [15:0] addr, input logic [15:0] inst,
                                input logic [15:0] pc2, input logic vld, input logic hlt,
                                input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.stl = stl; v.fl = fl; v.tgt = tgt;
        v.expAddr = addr; v.expInst = inst; v.expPc2 = pc2;
        v.expValid = vld; v.expHalt = hlt;
        v.expStallCnt = sc; v.expFlushCnt = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkOutputs(input string tag, input logic [15:0] addr, input logic [15:0] inst,
                              input logic [15:0] pc2, input logic vld, input logic hlt);
        chk({tag, " imem_addr"},      imem_addr,              addr);
        chk({tag, " if_id_inst"},     if_id_inst,             inst);
        chk({tag, " if_id_pc_plus2"}, if_id_pc_plus2,         pc2);
        chk({tag, " if_id_valid"},    {15'h0, if_id_valid},   {15'h0, vld});
        chk({tag, " fetch_halted"},   {15'h0, fetch_halted},  {15'h0, hlt});
    endtask

    initial begin
        //                stl   fl    tgt       addr      inst      pc2       v     h     sc  fc
        tbl[0]  = mk(1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0, 0, 0);
        tbl[1]  = mk(1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1234, 16'h0004, 1'b1, 1'b0, 0, 0);
        tbl[2]  = mk(1'b0, 1'b0, 16'h0000, 16'h0006, 16'h1234, 16'h0006, 1'b1, 1'b0, 0, 0);
        tbl[3]  = mk(1'b0, 1'b0, 16'h0000, 16'h0008, 16'h1234, 16'h0008, 1'b1, 1'b0, 0, 0);
        tbl[4]  = mk(1'b1, 1'b0, 16'h0000, 16'h0008, 16'h1234, 16'h0008, 1'b1, 1'b0, 1, 0);
        tbl[5]  = mk(1'b1, 1'b0, 16'h0000, 16'h0008, 16'h1234, 16'h0008, 1'b1, 1'b0, 2, 0);
        tbl[6]  = mk(1'b1, 1'b0, 16'h0000, 16'h0008, 16'h1234, 16'h0008, 1'b1, 1'b0, 3, 0);
        tbl[7]  = mk(1'b0, 1'b0, 16'h0000, 16'h000A, 16'h1234, 16'h000A, 1'b1, 1'b0, 3, 0);
        tbl[8]  = mk(1'b0, 1'b0, 16'h0000, 16'h000C, 16'h1234, 16'h000C, 1'b1, 1'b0, 3, 0);
        tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 16'h000E, 16'h1234, 16'h000E, 1'b1, 1'b0, 3, 0);
        tbl[10] = mk(1'b0, 1'b0, 16'h0000, 16'h0010, 16'h1234, 16'h0010, 1'b1, 1'b0, 3, 0);
        tbl[11] = mk(1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 3, 1);
        tbl[12] = mk(1'b0, 1'b0, 16'h0000, 16'h0042, 16'h1234, 16'h0042, 1'b1, 1'b0, 3, 1);
        tbl[13] = mk(1'b1, 1'b1, 16'h0080, 16'h0042, 16'h1234, 16'h0042, 1'b1, 1'b0, 4, 1);
        tbl[14] = mk(1'b0, 1'b0, 16'h0000, 16'h0044, 16'h1234, 16'h0044, 1'b1, 1'b0, 4, 1);
        tbl[15] = mk(1'b0, 1'b1, 16'h001C, 16'h001C, 16'h0000, 16'h0000, 1'b0, 1'b0, 4, 2);
        tbl[16] = mk(1'b0, 1'b0, 16'h0000, 16'h001E, 16'h1234, 16'h001E, 1'b1, 1'b0, 4, 2);
        tbl[17] = mk(1'b0, 1'b0, 16'h0000, 16'h0020, 16'h1234, 16'h0020, 1'b1, 1'b0, 4, 2);
        tbl[18] = mk(1'b0, 1'b0, 16'h0000, 16'h0020, 16'hF000, 16'h0022, 1'b1, 1'b1, 4, 2);
        tbl[19] = mk(1'b0, 1'b0, 16'h0000, 16'h0020, 16'hF000, 16'h0022, 1'b1, 1'b1, 4, 2);
        tbl[20] = mk(1'b1, 1'b0, 16'h0000, 16'h0020, 16'hF000, 16'h0022, 1'b1, 1'b1, 5, 2);
        tbl[21] = mk(1'b0, 1'b1, 16'h0030, 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0, 5, 3);
        tbl[22] = mk(1'b0, 1'b0, 16'h0000, 16'h0032, 16'h1234, 16'h0032, 1'b1, 1'b0, 5, 3);
        tbl[23] = mk(1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 5, 4);
        tbl[24] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 5, 4);
        tbl[25] = mk(1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0, 5, 4);

        rst       = 1'b1;
        stall     = 1'b0;
        if_flush  = 1'b0;
        br_target = 16'h0000;
        #2;
        chkOutputs("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset stall_cnt", stall_cnt, 16'h0000);
        chk("reset flush_cnt", flush_cnt, 16'h0000);
`endif
        #1 rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            stall     = tbl[i].stl;
            if_flush  = tbl[i].fl;
            br_target = tbl[i].tgt;
            @(posedge clk);
            #1;
            chkOutputs($sformatf("row%0d", i), tbl[i].expAddr, tbl[i].expInst,
                       tbl[i].expPc2, tbl[i].expValid, tbl[i].expHalt);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].expStallCnt);
            chk($sformatf("row%0d flush_cnt", i), flush_cnt, tbl[i].expFlushCnt);
`endif
        end

        // Async reset in the middle of a flush cycle: takes effect before any edge.
        stall     = 1'b0;
        if_flush  = 1'b1;
        br_target = 16'h0100;
        #3 rst = 1'b1;
        #1;
        chkOutputs("rstMidFlush", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("rstMidFlush stall_cnt", stall_cnt, 16'h0000);
        chk("rstMidFlush flush_cnt", flush_cnt, 16'h0000);
`endif
        @(posedge clk);
        #1;
        chkOutputs("rstHeld", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Flush already asserted as reset releases: first edge redirects.
        br_target = 16'h0050;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        chkOutputs("flushAtRelease", 16'h0050, 16'h0000, 16'h0000, 1'b0, 1'b0);
        if_flush = 1'b0;
        @(posedge clk);
        #1;
        chkOutputs("afterRelease", 16'h0052, 16'h1234, 16'h0052, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("afterRelease flush_cnt", flush_cnt, 16'h0001);
        chk("afterRelease stall_cnt", stall_cnt, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
